// File: rtl/relu_maxpool2d_stream.sv
// Streaming ReLU + 2x2/stride-2 max pool over a raster-order float32 feature map.
// Define RELU_MAXPOOL_RELU_EN to clamp negatives before pooling; otherwise raw floats are pooled.
module relu_maxpool2d_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 56,
  parameter int HEIGHT     = 56
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  frame_done
);

  localparam int HALF_W = WIDTH / 2;
  localparam int CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int RW     = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
  localparam int AW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  generate
    if (DATA_WIDTH != 32) begin : g_bad_data_width
      $error("relu_maxpool2d_stream supports only DATA_WIDTH = 32");
    end
    if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
      $error("relu_maxpool2d_stream requires an even WIDTH");
    end
    if ((HEIGHT % 2) != 0 || HEIGHT < 2) begin : g_bad_height
      $error("relu_maxpool2d_stream requires an even HEIGHT");
    end
  endgenerate

  // Returns b only when it is strictly larger, so ties keep the first-seen operand a.
  function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
`ifdef RELU_MAXPOOL_RELU_EN
    return (b[DATA_WIDTH-2:0] > a[DATA_WIDTH-2:0]) ? b : a;
`else
    logic b_wins;
    if (a[DATA_WIDTH-2:0] == '0 && b[DATA_WIDTH-2:0] == '0)
      b_wins = 1'b0;
    else if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
      b_wins = a[DATA_WIDTH-1];
    else if (a[DATA_WIDTH-1])
      b_wins = (b[DATA_WIDTH-2:0] < a[DATA_WIDTH-2:0]);
    else
      b_wins = (b[DATA_WIDTH-2:0] > a[DATA_WIDTH-2:0]);
    return b_wins ? b : a;
`endif
  endfunction

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] line_buf [HALF_W];
  logic [DATA_WIDTH-1:0] x_act;
  logic [DATA_WIDTH-1:0] buf_rd;
  logic [DATA_WIDTH-1:0] pool_h;
  logic [DATA_WIDTH-1:0] pool_v;
  logic [AW-1:0]         buf_idx;
  logic                  col_last;
  logic                  row_last;

`ifdef RELU_MAXPOOL_RELU_EN
  assign x_act = data_in[DATA_WIDTH-1] ? '0 : data_in;
`else
  assign x_act = data_in;
`endif

  assign col_last = (col == CW'(WIDTH - 1));
  assign row_last = (row == RW'(HEIGHT - 1));
  assign buf_idx  = AW'(col >> 1);
  assign buf_rd   = line_buf[buf_idx];
  assign pool_h   = fmax(hold, x_act);
  assign pool_v   = fmax(buf_rd, x_act);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col        <= '0;
      row        <= '0;
      hold       <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        // Odd rows fold the stored row-pair maximum into hold, then emit on the odd column.
        if (!row[0]) begin
          if (!col[0])
            hold <= x_act;
        end else if (!col[0]) begin
          hold <= pool_v;
        end else begin
          data_out   <= pool_h;
          valid_out  <= 1'b1;
          frame_done <= row_last && col_last;
        end
      end
    end
  end

  // Line buffer holds the even-row horizontal maxima; contents need no reset.
  always_ff @(posedge clk) begin
    if (valid_in && !row[0] && col[0])
      line_buf[buf_idx] <= pool_h;
  end

endmodule

// File: tb/tb_relu_maxpool2d_stream.sv
// Directed self-checking bench for relu_maxpool2d_stream on a 4x4 map.
// Expected values track RELU_MAXPOOL_RELU_EN the same way the design does.
module tb_relu_maxpool2d_stream;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic [31:0] data_out;
  logic        valid_out;
  logic        frame_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] q_data[$];
  logic        q_fd[$];
  int          q_cyc[$];

  relu_maxpool2d_stream #(.DATA_WIDTH(32), .WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .valid_in(valid_in),
    .data_out(data_out),
    .valid_out(valid_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every output pulse is logged with the clock-edge count at which it was registered.
  always @(negedge clk) begin
    if (valid_out) begin
      q_data.push_back(data_out);
      q_fd.push_back(frame_done);
      q_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    q_data.delete();
    q_fd.delete();
    q_cyc.delete();
  endtask

  // Called at a falling edge; presents one word for exactly one rising edge.
  task automatic applyStimulus(input logic [31:0] v, input int gap, output int acc);
    data_in  = v;
    valid_in = 1'b1;
    @(negedge clk);
    acc      = cyc;
    valid_in = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b0;
    valid_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_log();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_in  = 32'h3F800000;
      valid_in = i[0];
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_valid_out got=%b want=0", valid_out);
      end
      checks++;
      if (frame_done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_frame_done got=%b want=0", frame_done);
      end
      checks++;
      if (data_out !== 32'h00000000) begin
        failures++;
        $display("[TB] FAIL reset_data_out got=%h want=00000000", data_out);
      end
    end
    valid_in = 1'b0;
    rst      = 1'b1;
    clear_log();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b0 || frame_done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL idle_pulses got=%b%b want=00", valid_out, frame_done);
      end
      checks++;
      if (data_out !== 32'h00000000) begin
        failures++;
        $display("[TB] FAIL idle_data_out got=%h want=00000000", data_out);
      end
    end
  endtask

  task automatic test_basic_pool();
    logic [31:0] vec[8] = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3F000000,
                            32'h3F000000, 32'h3F800000, 32'h40400000, 32'h3F000000};
    int acc[8];
    do_reset();
    for (int i = 0; i < 8; i++) applyStimulus(vec[i], 0, acc[i]);
    repeat (2) @(negedge clk);
    checks++;
    if (q_data.size() !== 2) begin
      failures++;
      $display("[TB] FAIL basic_count got=%0d want=2", q_data.size());
    end
    if (q_data.size() >= 2) begin
      checks++;
      if (q_data[0] !== 32'h40000000 || q_cyc[0] !== acc[5]) begin
        failures++;
        $display("[TB] FAIL basic_out0 got=%h@%0d want=40000000@%0d", q_data[0], q_cyc[0], acc[5]);
      end
      checks++;
      if (q_data[1] !== 32'h40400000 || q_cyc[1] !== acc[7]) begin
        failures++;
        $display("[TB] FAIL basic_out1 got=%h@%0d want=40400000@%0d", q_data[1], q_cyc[1], acc[7]);
      end
      checks++;
      if (q_fd[0] !== 1'b0 || q_fd[1] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL basic_frame_done got=%b%b want=00", q_fd[0], q_fd[1]);
      end
    end
    checks++;
    if (valid_out !== 1'b0 || data_out !== 32'h40400000) begin
      failures++;
      $display("[TB] FAIL basic_hold got=%b/%h want=0/40400000", valid_out, data_out);
    end
  endtask

  task automatic test_relu_clamp();
    logic [31:0] vec[8] = '{32'hBF800000, 32'hC0000000, 32'h3F800000, 32'h3F800000,
                            32'h80000000, 32'hBF000000, 32'h3F800000, 32'h3F800000};
    logic [31:0] want0;
    int acc;
`ifdef RELU_MAXPOOL_RELU_EN
    want0 = 32'h00000000;
`else
    want0 = 32'h80000000;
`endif
    do_reset();
    for (int i = 0; i < 8; i++) applyStimulus(vec[i], 0, acc);
    repeat (2) @(negedge clk);
    checks++;
    if (q_data.size() !== 2) begin
      failures++;
      $display("[TB] FAIL clamp_count got=%0d want=2", q_data.size());
    end
    if (q_data.size() >= 2) begin
      checks++;
      if (q_data[0] !== want0) begin
        failures++;
        $display("[TB] FAIL clamp_negative_window got=%h want=%h", q_data[0], want0);
      end
      checks++;
      if (q_data[1] !== 32'h3F800000) begin
        failures++;
        $display("[TB] FAIL clamp_positive_window got=%h want=3f800000", q_data[1]);
      end
    end
  endtask

  task automatic test_gapped_stream();
    logic [31:0] vec[8] = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3F000000,
                            32'h3F000000, 32'h3F800000, 32'h40400000, 32'h3F000000};
    int acc[8];
    do_reset();
    for (int i = 0; i < 8; i++) applyStimulus(vec[i], 3, acc[i]);
    repeat (2) @(negedge clk);
    checks++;
    if (q_data.size() !== 2) begin
      failures++;
      $display("[TB] FAIL gapped_count got=%0d want=2", q_data.size());
    end
    if (q_data.size() >= 2) begin
      checks++;
      if (q_data[0] !== 32'h40000000 || q_cyc[0] !== acc[5]) begin
        failures++;
        $display("[TB] FAIL gapped_out0 got=%h@%0d want=40000000@%0d", q_data[0], q_cyc[0], acc[5]);
      end
      checks++;
      if (q_data[1] !== 32'h40400000 || q_cyc[1] !== acc[7]) begin
        failures++;
        $display("[TB] FAIL gapped_out1 got=%h@%0d want=40400000@%0d", q_data[1], q_cyc[1], acc[7]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] f2[16] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F000000,
                            32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h40800000,
                            32'h40A00000, 32'h3F000000, 32'h3F000000, 32'h3F000000,
                            32'h3F000000, 32'h40C00000, 32'h40E00000, 32'h3F000000};
    logic [31:0] want[8] = '{32'h42C80000, 32'h42C80000, 32'h42C80000, 32'h42C80000,
                             32'h40000000, 32'h40800000, 32'h40C00000, 32'h40E00000};
    int acc;
    do_reset();
    for (int i = 0; i < 16; i++) applyStimulus(32'h42C80000, 0, acc);
    for (int i = 0; i < 16; i++) applyStimulus(f2[i], 0, acc);
    repeat (2) @(negedge clk);
    checks++;
    if (q_data.size() !== 8) begin
      failures++;
      $display("[TB] FAIL wrap_count got=%0d want=8", q_data.size());
    end
    for (int i = 0; i < 8 && i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== want[i]) begin
        failures++;
        $display("[TB] FAIL wrap_data[%0d] got=%h want=%h", i, q_data[i], want[i]);
      end
      checks++;
      if (q_fd[i] !== (i == 3 || i == 7)) begin
        failures++;
        $display("[TB] FAIL wrap_frame_done[%0d] got=%b want=%b", i, q_fd[i], (i == 3 || i == 7));
      end
    end
  endtask

  task automatic test_mid_reset();
    int acc;
    do_reset();
    for (int i = 0; i < 6; i++) applyStimulus(32'h42C80000, 0, acc);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_log();
    for (int i = 0; i < 16; i++) applyStimulus(32'h3F800000, 0, acc);
    repeat (2) @(negedge clk);
    checks++;
    if (q_data.size() !== 4) begin
      failures++;
      $display("[TB] FAIL midreset_count got=%0d want=4", q_data.size());
    end
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== 32'h3F800000 || q_fd[i] !== (i == 3)) begin
        failures++;
        $display("[TB] FAIL midreset_out[%0d] got=%h/%b want=3f800000/%b", i, q_data[i], q_fd[i], (i == 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_pool();
    test_relu_clamp();
    test_gapped_stream();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/relu_maxpool2d_stream.md
Name: relu_maxpool2d_stream

Overview:
- Downstream consumer of one featuremap_conv2d filter output stream (float32 `data_out` / `valid_out`, raster order, no backpressure).
- Applies ReLU, then 2x2 stride-2 max pooling.
- Emits the pooled map in raster order for the next layer's input FIFO.
- One instance per filter.

Parameters:
- DATA_WIDTH, 32: IEEE-754 single-precision word width; only 32 is supported.
- WIDTH, 56: input feature-map columns. Must be even; an odd value is an elaboration error.
- HEIGHT, 56: input feature-map rows. Must be even.

Ports:
- clk  input  1  clock; all state is updated on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- data_in  input  DATA_WIDTH  conv+bias result, float32.
- valid_in  input  1  data_in is valid this cycle; there is no ready signal.
- data_out  output  DATA_WIDTH  pooled value, float32.
- valid_out  output  1  data_out is valid; single-cycle pulse per pooled value.
- frame_done  output  1  pulses together with valid_out for the last pooled value of a frame.

Behaviour:
- Reset (rst=0, asynchronous):
  - data_out=0, valid_out=0, frame_done=0.
  - col=0, row=0, hold register=0.
  - Line buffer contents are don't-care.
- Counters advance only on valid_in=1:
  - col counts 0..WIDTH-1; row counts 0..HEIGHT-1.
  - At col=WIDTH-1, col wraps to 0 and row increments.
  - At col=WIDTH-1 and row=HEIGHT-1, both wrap to 0. The next frame starts immediately; there is no idle gap requirement.
- ReLU (macro enabled): x' = 0x00000000 when sign bit=1, so -0.0 and all negatives map to +0.0. Otherwise x' = x.
- Compare: with ReLU, max() is an unsigned 31-bit compare of x'. A positive NaN compares larger than every other value; no special NaN handling.
- Even row (row[0]=0):
  - col even: hold <= x'.
  - col odd: buf[col>>1] <= max(hold, x').
  - No output.
- Odd row (row[0]=1):
  - col even: hold <= max(buf[col>>1], x').
  - col odd: data_out <= max(hold, x') and valid_out=1 on the next cycle.
- Latency: valid_out rises exactly 1 clk after the accepted odd-row, odd-col input.
- Outputs per frame: exactly (WIDTH/2)*(HEIGHT/2) values.
- valid_out is deasserted in every cycle where no output is produced. data_out holds its last value.
- frame_done=1 only alongside the output produced by input (row=HEIGHT-1, col=WIDTH-1).
- Gaps in valid_in: all state holds; gaps of any length may occur mid-pair or mid-row.
- Line buffer: WIDTH/2 entries of DATA_WIDTH, one write port and one read port.
  - An even-row write and an odd-row read never target the same entry in the same cycle.
  - Registers or inferred RAM are both acceptable.
- Reset asserted mid-frame: the partial frame is discarded and counters restart at (0,0). The first pooled output after release comes from fresh data only.

Optional Feature:
- Macro RELU_MAXPOOL_RELU_EN.
- Defined (default build): ReLU is applied before pooling as above; the compare is unsigned magnitude.
- Undefined: no ReLU; raw floats are pooled with a full sign-magnitude compare:
  - both positive: larger magnitude wins;
  - both negative: smaller magnitude wins;
  - mixed signs: the positive value wins;
  - -0.0 and +0.0 compare equal, and the first-seen operand is kept.
  - This build is used for layers whose ReLU lives elsewhere.

Test Plan:
- Reset values: hold rst=0 and toggle clk and valid_in. Required: valid_out=0, frame_done=0, data_out=0x00000000. After release with no valid_in, outputs stay 0.
- Basic pool (WIDTH=4, HEIGHT=4, macro on):
  - row0 = 1.0, 2.0, 0.5, 0.5 (0x3F800000, 0x40000000, 0x3F000000, 0x3F000000).
  - row1 = 0.5, 1.0, 3.0, 0.5.
  - Required: 0x40000000 one cycle after row1 col1, then 0x40400000 one cycle after row1 col3. No other valid_out pulses.
- ReLU clamp: a 2x2 window of all negatives (0xBF800000, 0xC0000000, 0x80000000, 0xBF000000). Required: 0x00000000 with macro defined; 0x80000000 (-0.0) with macro undefined.
- Gapped stream: the basic pool pattern with valid_in=0 inserted for 3 cycles between every input. Required: identical data_out values, each arriving 1 cycle after its triggering input.
- Frame wrap/frame_done (4x4): two back-to-back frames. Required:
  - frame_done pulses only with the 4th and 8th outputs;
  - the second frame's outputs are independent of the first frame's buffer contents.
- Mid-frame reset: drive rst low after 6 inputs of a frame, release, then stream a full 4x4 frame of 1.0 (0x3F800000). Required: exactly 4 outputs, all 0x3F800000, and frame_done on the 4th.
